// File: rtl/msx_cycle_sequencer.sv
// Runs one MSX cartridge-slot bus cycle (mem/io read/write, M1 fetch) per latched request:
// setup, strobe with /WAIT extension and timeout, hold, then a one-cycle done pulse.
module msx_cycle_sequencer #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_rd,
  input  logic        req_io,
  input  logic        req_slot,
  input  logic        req_m1,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        timeout,
  output logic [15:0] maddr,
  output logic [7:0]  mdata_out,
  output logic        mdata_oe,
  input  logic [7:0]  mdata_in,
  output logic [1:0]  msltsl_n,
  output logic        mmreq_n,
  output logic        miorq_n,
  output logic        mrd_n,
  output logic        mwr_n,
  output logic        mm1_n,
  input  logic        mwait_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] nw, nw_nxt;
  logic        cyc_rd, cyc_io, cyc_slot, cyc_m1, abort;
  logic        cyc_rd_nxt, cyc_io_nxt, cyc_slot_nxt, cyc_m1_nxt, abort_nxt;
  logic        wait_m, wait_s;

  logic        ready_nxt, busy_nxt, done_nxt, timeout_nxt, mdata_oe_nxt;
  logic [7:0]  rdata_nxt, mdata_out_nxt;
  logic [15:0] maddr_nxt;
  logic [1:0]  msltsl_n_nxt;
  logic        mmreq_n_nxt, miorq_n_nxt, mrd_n_nxt, mwr_n_nxt, mm1_n_nxt;

  // /WAIT is asynchronous to clk; idle level is "not waiting"
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_m <= 1'b1;
      wait_s <= 1'b1;
    end else begin
      wait_m <= mwait_n;
      wait_s <= wait_m;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    nw_nxt        = nw;
    cyc_rd_nxt    = cyc_rd;
    cyc_io_nxt    = cyc_io;
    cyc_slot_nxt  = cyc_slot;
    cyc_m1_nxt    = cyc_m1;
    abort_nxt     = abort;
    ready_nxt     = ready;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    timeout_nxt   = timeout;
    rdata_nxt     = rdata;
    maddr_nxt     = maddr;
    mdata_out_nxt = mdata_out;
    mdata_oe_nxt  = mdata_oe;
    msltsl_n_nxt  = msltsl_n;
    mmreq_n_nxt   = mmreq_n;
    miorq_n_nxt   = miorq_n;
    mrd_n_nxt     = mrd_n;
    mwr_n_nxt     = mwr_n;
    mm1_n_nxt     = mm1_n;
    case (state)
      IDLE: begin
        if (req) begin
          cyc_rd_nxt   = req_rd;
          cyc_io_nxt   = req_io;
          cyc_slot_nxt = req_slot;
          cyc_m1_nxt   = req_m1;
          abort_nxt    = 1'b0;
          maddr_nxt    = req_addr;
          if (!req_rd) begin
            mdata_out_nxt = req_wdata;
            mdata_oe_nxt  = 1'b1;
          end
          cnt_nxt   = 8'(SETUP_CYC - 1);
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          mmreq_n_nxt  = cyc_io;
          miorq_n_nxt  = !cyc_io;
          mrd_n_nxt    = !cyc_rd;
          mwr_n_nxt    = cyc_rd;
          mm1_n_nxt    = !(cyc_m1 && cyc_rd && !cyc_io);
          msltsl_n_nxt = cyc_io ? 2'b11 : (cyc_slot ? 2'b01 : 2'b10);
          cnt_nxt      = 8'(STROBE_CYC - 1);
          nw_nxt       = 16'd0;
          state_nxt    = STROBE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      STROBE: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (wait_s || nw == 16'(WAIT_TIMEOUT)) begin
          // Release strobes; a timed-out read returns an open-bus value
          mmreq_n_nxt  = 1'b1;
          miorq_n_nxt  = 1'b1;
          mrd_n_nxt    = 1'b1;
          mwr_n_nxt    = 1'b1;
          mm1_n_nxt    = 1'b1;
          msltsl_n_nxt = 2'b11;
          abort_nxt    = !wait_s;
          if (cyc_rd) rdata_nxt = wait_s ? mdata_in : 8'hFF;
          cnt_nxt   = 8'(HOLD_CYC - 1);
          state_nxt = HOLD;
        end else begin
          nw_nxt = nw + 16'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          done_nxt     = 1'b1;
          timeout_nxt  = abort;
          mdata_oe_nxt = 1'b0;
          ready_nxt    = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      nw        <= 16'd0;
      cyc_rd    <= 1'b0;
      cyc_io    <= 1'b0;
      cyc_slot  <= 1'b0;
      cyc_m1    <= 1'b0;
      abort     <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      rdata     <= 8'hFF;
      maddr     <= 16'd0;
      mdata_out <= 8'd0;
      mdata_oe  <= 1'b0;
      msltsl_n  <= 2'b11;
      mmreq_n   <= 1'b1;
      miorq_n   <= 1'b1;
      mrd_n     <= 1'b1;
      mwr_n     <= 1'b1;
      mm1_n     <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      nw        <= nw_nxt;
      cyc_rd    <= cyc_rd_nxt;
      cyc_io    <= cyc_io_nxt;
      cyc_slot  <= cyc_slot_nxt;
      cyc_m1    <= cyc_m1_nxt;
      abort     <= abort_nxt;
      ready     <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      rdata     <= rdata_nxt;
      maddr     <= maddr_nxt;
      mdata_out <= mdata_out_nxt;
      mdata_oe  <= mdata_oe_nxt;
      msltsl_n  <= msltsl_n_nxt;
      mmreq_n   <= mmreq_n_nxt;
      miorq_n   <= miorq_n_nxt;
      mrd_n     <= mrd_n_nxt;
      mwr_n     <= mwr_n_nxt;
      mm1_n     <= mm1_n_nxt;
    end
  end

endmodule

// File: tb/tb_msx_cycle_sequencer.sv
// Directed bench for msx_cycle_sequencer: read, write, /WAIT extension, timeout,
// mid-cycle reset and back-to-back requests, all against hand-computed timing.
module tb_msx_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, req, req_rd, req_io, req_slot, req_m1;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, mdata_in;
  logic        mwait_n;
  logic        ready, busy, done, timeout, mdata_oe;
  logic [7:0]  rdata, mdata_out;
  logic [15:0] maddr;
  logic [1:0]  msltsl_n;
  logic        mmreq_n, miorq_n, mrd_n, mwr_n, mm1_n;

  int errors = 0;
  int checks = 0;

  // {mmreq_n, miorq_n, mrd_n, mwr_n, mm1_n}
  logic [4:0] strobes;
  assign strobes = {mmreq_n, miorq_n, mrd_n, mwr_n, mm1_n};

  msx_cycle_sequencer #(
    .SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(1), .WAIT_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rd(req_rd), .req_io(req_io),
    .req_slot(req_slot), .req_m1(req_m1), .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .busy(busy), .done(done), .rdata(rdata), .timeout(timeout),
    .maddr(maddr), .mdata_out(mdata_out), .mdata_oe(mdata_oe), .mdata_in(mdata_in),
    .msltsl_n(msltsl_n), .mmreq_n(mmreq_n), .miorq_n(miorq_n), .mrd_n(mrd_n),
    .mwr_n(mwr_n), .mm1_n(mm1_n), .mwait_n(mwait_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic rd, input logic io, input logic slot, input logic m1,
                       input logic [15:0] addr, input logic [7:0] wdata);
    req = 1'b1; req_rd = rd; req_io = io; req_slot = slot; req_m1 = m1;
    req_addr = addr; req_wdata = wdata;
    step();
    req = 1'b0;
  endtask

  initial begin
    int pulses;
    int budget;
    logic m1_ok;
    reset = 1'b1; req = 1'b0; req_rd = 1'b0; req_io = 1'b0; req_slot = 1'b0;
    req_m1 = 1'b0; req_addr = 16'h0; req_wdata = 8'h0; mdata_in = 8'h00; mwait_n = 1'b1;
    step(2);
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", strobes, 5'b11111);
    chk("rst_slt", msltsl_n, 2'b11);
    chk("rst_addr_data", {maddr, mdata_out, mdata_oe}, 25'h0);
    chk("rst_rdata", rdata, 8'hFF);
    chk("rst_done_to", {done, timeout}, 2'b00);

    // Memory read, slot 1, zero wait
    mdata_in = 8'h5A;
    issue(1, 0, 1, 0, 16'h4000, 8'h00);
    chk("mr_t0_busy", {busy, ready}, 2'b10);
    chk("mr_t0_addr", maddr, 16'h4000);
    chk("mr_t0_strobes", strobes, 5'b11111);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("mr_strobes", strobes, 5'b01011);
      chk("mr_slt", msltsl_n, 2'b01);
    end
    step();
    chk("mr_t5_release", {strobes, msltsl_n, done}, {5'b11111, 2'b11, 1'b0});
    step();
    chk("mr_t6_done", done, 1);
    chk("mr_rdata", rdata, 8'h5A);
    chk("mr_timeout", timeout, 0);
    chk("mr_t6_ready", {ready, busy}, 2'b10);
    step();
    chk("mr_done_pulse", done, 0);

    // I/O write
    mdata_in = 8'h99;
    issue(0, 1, 0, 0, 16'h0098, 8'h3C);
    chk("iw_t0_data", {mdata_oe, mdata_out}, {1'b1, 8'h3C});
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("iw_strobes", strobes, 5'b10101);
      chk("iw_slt", msltsl_n, 2'b11);
    end
    step();
    chk("iw_t5_hold", {strobes, mdata_oe, mdata_out, maddr}, {5'b11111, 1'b1, 8'h3C, 16'h0098});
    step();
    chk("iw_t6_done", {done, mdata_oe}, 2'b10);
    chk("iw_rdata_kept", rdata, 8'h5A);

    // /WAIT extension: released just after edge T0+8
    step();
    mwait_n = 1'b0; mdata_in = 8'h77;
    step(3);
    issue(1, 0, 0, 0, 16'h8000, 8'h00);
    step(7);
    chk("wx_t7_ext", strobes, 5'b01011);
    step();
    mwait_n = 1'b1;
    step(2);
    chk("wx_t10_ext", {strobes, msltsl_n}, {5'b01011, 2'b10});
    step();
    chk("wx_t11_release", {strobes, done}, {5'b11111, 1'b0});
    step();
    chk("wx_t12_done", {done, timeout, rdata}, {1'b1, 1'b0, 8'h77});

    // Timeout with /WAIT stuck low
    step();
    mwait_n = 1'b0; mdata_in = 8'h11;
    step(3);
    issue(1, 0, 1, 0, 16'h1234, 8'h00);
    step(20);
    chk("to_t20_asserted", strobes, 5'b01011);
    step();
    chk("to_t21_release", {strobes, done}, {5'b11111, 1'b0});
    step();
    chk("to_t22_done", {done, timeout, rdata}, {1'b1, 1'b1, 8'hFF});
    mwait_n = 1'b1;
    step();
    chk("to_timeout_held", {done, timeout}, 2'b01);
    step(3);

    // Reset in the middle of a read
    mdata_in = 8'h42;
    issue(1, 0, 1, 0, 16'h5555, 8'h00);
    step(2);
    chk("rm_t2_asserted", strobes, 5'b01011);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_strobes", {strobes, msltsl_n}, {5'b11111, 2'b11});
    chk("rm_ready_busy", {ready, busy}, 2'b10);
    chk("rm_outputs", {maddr, timeout, rdata}, {16'h0, 1'b0, 8'hFF});
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) pulses++;
      step();
    end
    chk("rm_no_done", pulses, 0);

    // Back-to-back: M1 fetch then memory write, req held high
    mdata_in = 8'hED;
    req = 1'b1; req_rd = 1'b1; req_io = 1'b0; req_slot = 1'b0; req_m1 = 1'b1;
    req_addr = 16'h0000; req_wdata = 8'h00;
    step();
    req_rd = 1'b0; req_slot = 1'b1; req_addr = 16'hA000; req_wdata = 8'hC3;
    step();
    chk("bb_m1_strobes", {strobes, msltsl_n}, {5'b01010, 2'b10});
    step(4);
    chk("bb_t5_release", strobes, 5'b11111);
    step();
    chk("bb_first_done", {done, ready, rdata}, {1'b1, 1'b1, 8'hED});
    step();
    chk("bb_second_accept", {busy, ready, done}, 3'b100);
    chk("bb_second_bus", {maddr, mdata_oe, mdata_out}, {16'hA000, 1'b1, 8'hC3});
    req = 1'b0;
    m1_ok = 1'b1;
    budget = 0;
    while (!done && budget < 20) begin
      step();
      budget++;
      if (!mm1_n) m1_ok = 1'b0;
      if (budget == 2) chk("bb_wr_strobes", {strobes, msltsl_n}, {5'b01101, 2'b01});
    end
    chk("bb_second_done_cycles", budget, 6);
    chk("bb_m1_never", m1_ok, 1);
    chk("bb_wr_rdata_kept", rdata, 8'hED);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msx_cycle_sequencer.md
# msx_cycle_sequencer

Sequences one complete MSX cartridge-slot bus cycle (memory read/write, I/O read/write, M1 opcode fetch) from a single latched host request. It sits between the host-side command decoder and the MSX pins. It owns the address/data setup, strobe assertion, /WAIT extension with timeout, and the hold phase, so strobe timing is produced in hardware and not by host software toggling control bits. Exactly one bus cycle is in flight at a time.

## Interface
Parameters:
- SETUP_CYC, 1, clk cycles address/data are stable before strobes assert (1..255)
- STROBE_CYC, 4, minimum clk cycles strobes stay asserted (1..255)
- HOLD_CYC, 1, clk cycles address/data held after strobes deassert (1..255)
- WAIT_TIMEOUT, 255, maximum /WAIT extension cycles before abort (1..65535)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  request; accepted on a rising edge where req & ready
- req_rd  in  1  1=read, 0=write
- req_io  in  1  1=I/O cycle, 0=memory cycle
- req_slot  in  1  selects msltsl_n[req_slot] (memory cycles only)
- req_m1  in  1  opcode fetch; honoured only for memory reads
- req_addr  in  16  bus address
- req_wdata  in  8  write data
- ready  out  1  high in IDLE
- busy  out  1  high while a cycle is in flight
- done  out  1  one-cycle completion pulse
- rdata  out  8  read data, valid from done onward
- timeout  out  1  valid with done; 1 = cycle aborted by WAIT_TIMEOUT
- maddr  out  16  MSX address bus
- mdata_out  out  8  MSX data to drive
- mdata_oe  out  1  data bus output enable
- mdata_in  in  8  MSX data bus input
- msltsl_n, out, 2, slot selects, active low
- mmreq_n, miorq_n, mrd_n, mwr_n, mm1_n  out  1 each  active-low strobes
- mwait_n  in  1  asynchronous MSX /WAIT

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- IDLE: all strobes 1, msltsl_n=2'b11, mdata_oe=0, ready=1, busy=0. On req: latch every req_* field, drive maddr=req_addr, and for writes drive mdata_out=req_wdata with mdata_oe=1. Go to SETUP with busy=1.
- SETUP: lasts SETUP_CYC cycles, then go to STROBE and assert strobes:
  - mmreq_n is asserted for memory cycles and miorq_n for I/O cycles.
  - mrd_n is asserted for reads and mwr_n for writes.
  - msltsl_n[slot] is asserted for memory cycles only.
  - mm1_n is asserted only when m1 & rd & !io.
- STROBE: lasts at least STROBE_CYC cycles. From the last minimum cycle onward, evaluate wait_s each edge:
  - wait_s=1: deassert all strobes. For a read, capture rdata=mdata_in on the same edge. Go to HOLD.
  - wait_s=0: extend by one cycle and increment the wait counter Nw.
  - Nw reaching WAIT_TIMEOUT: deassert strobes, set rdata=8'hFF if the cycle is a read, set timeout=1, go to HOLD.
- HOLD: maddr, mdata_out and mdata_oe stay unchanged for HOLD_CYC cycles. Then go to IDLE, pulse done for one cycle, and drop mdata_oe.
- wait_s is mwait_n through a 2-flop synchronizer reset to 1.
- Writes leave rdata unchanged. timeout holds its value until the next done.
- req_* inputs are ignored while busy.
- Reset mid-cycle: on the next edge, the FSM goes to IDLE and all outputs take their reset values. No done pulse is issued.
- Reset values: strobes 1, msltsl_n 2'b11, maddr 0, mdata_out 0, mdata_oe 0, ready 1, busy 0, done 0, rdata 8'hFF, timeout 0.

## Timing
- T0 is the acceptance edge. Let S=SETUP_CYC, W=STROBE_CYC, H=HOLD_CYC.
- Strobes assert at edge T0+S and deassert at edge T0+S+W+Nw.
- done is high in the cycle after edge T0+S+W+Nw+H. ready and busy change on that same edge.
- Zero-wait latency with default parameters: done at T0+6.
- /WAIT latency: a level change on mwait_n becomes visible to the FSM 2 edges after it is sampled by the first flop.
- Back-to-back: a req present during the done cycle is accepted on the next edge. There are no dead cycles beyond HOLD.

## Test plan
- Memory read, defaults, slot 1, addr 16'h4000, mdata_in 8'h5A, mwait_n=1 -> the following responses are required:
  - msltsl_n=2'b01, mmreq_n=0 and mrd_n=0 from edge T0+1 to T0+5.
  - done at T0+6, rdata=8'h5A, timeout=0.
- I/O write, addr 16'h0098, data 8'h3C -> the following responses are required:
  - miorq_n=0 and mwr_n=0 for T0+1..T0+5, msltsl_n=2'b11.
  - mdata_oe=1 and mdata_out=8'h3C from T0 until done at T0+6, then mdata_oe=0.
- Wait extension: mwait_n=0 until it is driven 1 at edge T0+8 -> strobes deassert at T0+11 (Nw=6), done at T0+12, timeout=0.
- Timeout: WAIT_TIMEOUT=16, mwait_n stuck at 0, read -> strobes deassert at T0+21, done at T0+22, timeout=1, rdata=8'hFF.
- Reset asserted during edge T0+3 of a read -> the next edge returns all strobes to 1, msltsl_n to 2'b11, ready to 1 and busy to 0, with no done pulse.
- Back-to-back with req held high: first an M1 fetch at addr 16'h0000, then a memory write -> mm1_n=0 together with mmreq_n=0 and mrd_n=0 on the first cycle. The second cycle is accepted on the edge after the first done, and mm1_n stays 1 throughout it.
